// File: rtl/mem_fetch_pkg.sv
// Shared types and widths for the byte-wide memory word fetcher.
package mem_fetch_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRdLo  = 3'd1,
        StRdHi  = 3'd2,
        StWrite = 3'd3,
        StAbort = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/wait_timer.sv
// Per-byte wait counter; expired is high once MAX_WAIT ready-less edges have been counted.
module wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CntW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (tick && !expired) begin
            count_q <= count_q + CntW'(1);
        end
    end

    assign expired = (count_q == MaxCnt);

endmodule

// File: rtl/mem_word_fetch.sv
// Fetches an 8- or 16-bit little-endian operand over an 8-bit memory bus and
// presents it to the 16-bit register bus with a one-cycle load strobe.
module mem_word_fetch
    import mem_fetch_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] addr,
    input  logic              mode_16,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [BYTE_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic [WORD_W-1:0] bus_out,
    output logic              load_l,
    output logic              load_16,
    output logic              busy,
    output logic              done,
    output logic              error
);

    fetch_state_e      state_q;
    logic [WORD_W-1:0] addr_q;
    logic              mode_q;
    logic [BYTE_W-1:0] lo_q;

    logic in_read;
    logic timer_clear;
    logic timer_tick;
    logic timer_expired;

    // One timer serves both byte phases; a ready edge restarts it for the next byte.
    assign in_read     = (state_q == StRdLo) || (state_q == StRdHi);
    assign timer_clear = !in_read || mem_ready;
    assign timer_tick  = in_read && !mem_ready;
    assign busy        = (state_q != StIdle);

    wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .tick   (timer_tick),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            mode_q   <= 1'b0;
            lo_q     <= '0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            bus_out  <= '0;
            load_l   <= 1'b0;
            load_16  <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            // Strobes and the bus are only non-zero for the single WRITE/ABORT cycle.
            bus_out <= '0;
            load_l  <= 1'b0;
            load_16 <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StRdLo;
                        addr_q   <= addr;
                        mode_q   <= mode_16;
                        mem_addr <= addr;
                        mem_rd   <= 1'b1;
                    end
                end
                StRdLo: begin
                    if (mem_ready) begin
                        lo_q <= mem_data;
                        if (mode_q) begin
                            state_q  <= StRdHi;
                            mem_addr <= addr_q + WORD_W'(1);
                        end else begin
                            state_q <= StWrite;
                            mem_rd  <= 1'b0;
                            bus_out <= {{(WORD_W - BYTE_W){1'b0}}, mem_data};
                            load_l  <= 1'b1;
                            done    <= 1'b1;
                        end
                    end else if (timer_expired) begin
                        state_q <= StAbort;
                        mem_rd  <= 1'b0;
                        error   <= 1'b1;
                    end
                end
                StRdHi: begin
                    if (mem_ready) begin
                        state_q <= StWrite;
                        mem_rd  <= 1'b0;
                        bus_out <= {mem_data, lo_q};
                        load_16 <= 1'b1;
                        done    <= 1'b1;
                    end else if (timer_expired) begin
                        state_q <= StAbort;
                        mem_rd  <= 1'b0;
                        error   <= 1'b1;
                    end
                end
                StWrite, StAbort: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    mem_rd  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_word_fetch.sv
// Randomized bench: per-fetch timelines are computed from the fetch plan and checked every cycle.
module tb_mem_word_fetch;

    localparam int unsigned MaxWait = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] addr;
    logic        mode_16;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic [15:0] bus_out;
    logic        load_l;
    logic        load_16;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    mem_word_fetch #(
        .MAX_WAIT(MaxWait)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .addr     (addr),
        .mode_16  (mode_16),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .mem_ready(mem_ready),
        .bus_out  (bus_out),
        .load_l   (load_l),
        .load_16  (load_16),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    typedef struct packed {
        logic        busy;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] bus;
        logic        ll;
        logic        l16;
        logic        dn;
        logic        er;
    } exp_t;

    exp_t        exp_q;
    logic        check_en = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] last_addr;

    function automatic exp_t mk(logic b, logic rd, logic [15:0] a, logic [15:0] bus,
                                logic ll, logic l16, logic dn, logic er);
        exp_t e;
        e.busy = b;
        e.rd   = rd;
        e.addr = a;
        e.bus  = bus;
        e.ll   = ll;
        e.l16  = l16;
        e.dn   = dn;
        e.er   = er;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        return mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // mem_addr is only meaningful while a read is requested.
    always @(negedge clk) begin
        if (check_en) begin
            vectors++;
            if (busy !== exp_q.busy || mem_rd !== exp_q.rd || bus_out !== exp_q.bus ||
                load_l !== exp_q.ll || load_16 !== exp_q.l16 || done !== exp_q.dn ||
                error !== exp_q.er || (exp_q.rd && mem_addr !== exp_q.addr)) begin
                miscompares++;
                $display("FAIL cycle_outputs @%0t got busy=%b rd=%b addr=%h bus=%h ll=%b l16=%b done=%b err=%b want busy=%b rd=%b addr=%h bus=%h ll=%b l16=%b done=%b err=%b",
                         $time, busy, mem_rd, mem_addr, bus_out, load_l, load_16, done, error,
                         exp_q.busy, exp_q.rd, exp_q.addr, exp_q.bus, exp_q.ll, exp_q.l16,
                         exp_q.dn, exp_q.er);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Drive one cycle's inputs and the outputs that cycle must show.
    task automatic step(input logic s, input logic rdy, input logic [7:0] d, input logic [15:0] a,
                        input logic m, input logic rst, input exp_t e);
        @(posedge clk);
        #1;
        start     = s;
        mem_ready = rdy;
        mem_data  = d;
        addr      = a;
        mode_16   = m;
        reset     = rst;
        exp_q     = e;
        check_en  = 1'b1;
    endtask

    function automatic logic busy_start(input logic hold);
        return hold || ($urandom_range(0, 3) == 0);
    endfunction

    // A byte phase: ready arrives after w wait cycles, or never if w exceeds MaxWait.
    task automatic read_phase(input logic [15:0] a, input int w, input logic [7:0] d,
                              input logic hold, inout int cyc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i <= int'(MaxWait); i++) begin
            logic rdy;
            rdy = (i == w);
            step(busy_start(hold), rdy, rdy ? d : 8'($urandom), 16'($urandom), 1'($urandom),
                 1'b0, mk(1'b1, 1'b1, a, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
            cyc++;
            last_addr = mem_addr;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic fetch(input logic [15:0] a, input logic m, input int wlo, input int whi,
                         input logic [7:0] lo, input logic [7:0] hi, input logic hold,
                         output int cyc);
        logic        ok;
        logic [15:0] word;
        cyc = 0;
        step(1'b1, 1'($urandom), 8'($urandom), a, m, 1'b0, idle_exp());
        read_phase(a, wlo, lo, hold, cyc, ok);
        if (ok && m) read_phase(a + 16'd1, whi, hi, hold, cyc, ok);
        cyc++;
        if (!ok) begin
            step(busy_start(hold), 1'($urandom), 8'($urandom), 16'($urandom), 1'($urandom), 1'b0,
                 mk(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));
        end else begin
            word = m ? {hi, lo} : {8'h00, lo};
            step(busy_start(hold), 1'($urandom), 8'($urandom), 16'($urandom), 1'($urandom), 1'b0,
                 mk(1'b1, 1'b0, 16'h0000, word, !m, m, 1'b1, 1'b0));
        end
    endtask

    task automatic gap(input int n);
        repeat (n) step(1'b0, 1'($urandom), 8'($urandom), 16'($urandom), 1'($urandom), 1'b0,
                        idle_exp());
    endtask

    function automatic int pick_wait();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return int'(MaxWait) + 1;
        if (sel == 1) return int'(MaxWait);
        return $urandom_range(0, 3);
    endfunction

    initial begin
        int cyc;
        reset     = 1'b1;
        start     = 1'b0;
        addr      = 16'h0000;
        mode_16   = 1'b0;
        mem_data  = 8'h00;
        mem_ready = 1'b0;
        exp_q     = idle_exp();

        step(1'b1, 1'b1, 8'hFF, 16'hFFFF, 1'b1, 1'b1, idle_exp());
        step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, idle_exp());
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_bus", 32'(bus_out), 32'h0);
        step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, idle_exp());

        // Reset while in RD_LO.
        step(1'b1, 1'b0, 8'h00, 16'h4000, 1'b0, 1'b0, idle_exp());
        step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1,
             mk(1'b1, 1'b1, 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, idle_exp());
        check("reset_mid_busy", 32'(busy), 32'd0);
        check("reset_mid_rd", 32'(mem_rd), 32'd0);

        fetch(16'h1234, 1'b0, 0, 0, 8'hAB, 8'h00, 1'b0, cyc);
        check("t8_cycle", 32'(cyc), 32'd2);
        check("t8_bus", 32'(bus_out), 32'h00AB);
        check("t8_load_l", 32'(load_l), 32'd1);
        gap(1);

        fetch(16'h2000, 1'b1, 2, 1, 8'h34, 8'h12, 1'b0, cyc);
        check("t16_cycle", 32'(cyc), 32'd6);
        check("t16_bus", 32'(bus_out), 32'h1234);
        check("t16_load_16", 32'(load_16), 32'd1);
        gap(1);

        fetch(16'hFFFF, 1'b1, 0, 0, 8'h5A, 8'hC3, 1'b0, cyc);
        check("wrap_addr", 32'(last_addr), 32'h0000);
        check("wrap_cycle", 32'(cyc), 32'd3);
        gap(1);

        fetch(16'h0100, 1'b0, int'(MaxWait) + 1, 0, 8'h11, 8'h00, 1'b0, cyc);
        check("timeout_cycle", 32'(cyc), 32'd17);
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_no_load", 32'(load_l | load_16), 32'd0);
        gap(1);

        fetch(16'h0200, 1'b0, int'(MaxWait), 0, 8'h77, 8'h00, 1'b0, cyc);
        check("last_edge_cycle", 32'(cyc), 32'd17);
        check("last_edge_done", 32'(done), 32'd1);

        // Back-to-back with start held high throughout.
        fetch(16'h3000, 1'b1, 1, 0, 8'h01, 8'h02, 1'b1, cyc);
        fetch(16'h3100, 1'b1, 0, 2, 8'h03, 8'h04, 1'b1, cyc);
        gap(2);

        for (int n = 0; n < 300; n++) begin
            fetch(16'($urandom), 1'($urandom), pick_wait(), pick_wait(), 8'($urandom),
                  8'($urandom), 1'($urandom), cyc);
            gap($urandom_range(0, 2));
        end

        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
